wb_port_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and a long-latency execution unit (iterative divider / multi-cycle load) that completes out of order. Pipeline writes take priority, long-latency results wait in a small FIFO, and a starvation counter forces a one-cycle pipeline stall to drain the FIFO. Buffered results that the pipeline later overwrites are killed to preserve architectural write order. The block sits between writeback result selection and the register file.

---
 rtl/wb_port_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results queue in a small FIFO with kill-on-overwrite and a starvation-forced drain.
module wb_port_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   regWrite_W,
  input  logic [ADDR_WIDTH-1:0]  rd_W,
  input  logic [WIDTH-1:0]       result_W,
  input  logic                   ll_valid,
  input  logic [ADDR_WIDTH-1:0]  ll_rd,
  input  logic [WIDTH-1:0]       ll_data,
  output logic                   ll_ready,
  output logic                   rf_we,
  output logic [ADDR_WIDTH-1:0]  rf_addr,
  output logic [WIDTH-1:0]       rf_wd,
  output logic                   stall_W,
  output logic [$clog2(DEPTH):0] pending_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_DRAIN   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH-1:0] ent_rd_q   [DEPTH];
  logic [WIDTH-1:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0]      ent_kill_q;

  logic empty_s, head_kill_s, pipe_wr_s, pop_s, enq_s;

  assign empty_s       = (count_q == {CW{1'b0}});
  assign head_kill_s   = !empty_s && ent_kill_q[rd_ptr_q];
  assign ll_ready      = (count_q != FULL_CNT);
  assign pending_count = count_q;

  // State register: FSM state, occupancy and starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= {CW{1'b0}};
      starve_q <= {SW{1'b0}};
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Next-state: DRAIN is entered once the head has been passed over STARVE_MAX times.
  always_comb begin
    count_d = count_q + CW'(enq_s) - CW'(pop_s);
    if (empty_s || pop_s) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q == STARVE_TOP) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + SW'(1'b1);
    end
    if (count_d == {CW{1'b0}}) begin
      state_d = S_IDLE;
    end else if (starve_d == STARVE_TOP) begin
      state_d = S_DRAIN;
    end else begin
      state_d = S_PENDING;
    end
  end

  // Port selection; a killed head is discarded instead of stalling the pipeline.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = ent_rd_q[rd_ptr_q];
    rf_wd   = ent_data_q[rd_ptr_q];
    case (state_q)
      S_DRAIN: stall_W = !head_kill_s;
      default: stall_W = 1'b0;
    endcase
    pipe_wr_s = rst_n && regWrite_W && (rd_W != {ADDR_WIDTH{1'b0}}) && !stall_W;
    pop_s     = rst_n && !empty_s && (head_kill_s || !pipe_wr_s);
    if (pipe_wr_s) begin
      rf_we   = 1'b1;
      rf_addr = rd_W;
      rf_wd   = result_W;
    end else if (pop_s && !head_kill_s) begin
      rf_we = 1'b1;
    end else begin
      rf_we = 1'b0;
    end
    enq_s = rst_n && ll_valid && ll_ready && (ll_rd != {ADDR_WIDTH{1'b0}}) &&
            !(pipe_wr_s && (ll_rd == rd_W));
  end

  // FIFO storage, pointers and kill marking by younger pipeline writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      ent_kill_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ent_rd_q[i]   <= {ADDR_WIDTH{1'b0}};
        ent_data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pipe_wr_s && (ent_rd_q[i] == rd_W)) begin
          ent_kill_q[i] <= 1'b1;
        end
      end
      if (enq_s) begin
        ent_rd_q[wr_ptr_q]   <= ll_rd;
        ent_data_q[wr_ptr_q] <= ll_data;
        ent_kill_q[wr_ptr_q] <= 1'b0;
        wr_ptr_q             <= wr_ptr_q + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
  localparam int PCW   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             regWrite_W;
  logic [AW-1:0]    rd_W;
  logic [WIDTH-1:0] result_W;
  logic             ll_valid;
  logic [AW-1:0]    ll_rd;
  logic [WIDTH-1:0] ll_data;
  logic             ll_ready;
  logic             rf_we;
  logic [AW-1:0]    rf_addr;
  logic [WIDTH-1:0] rf_wd;
  logic             stall_W;
  logic [PCW-1:0]   pending_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
    bit               kill;
  } ent_t;

  wb_port_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .regWrite_W(regWrite_W), .rd_W(rd_W), .result_W(result_W),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
    .stall_W(stall_W), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rw, input logic [AW-1:0] rd, input logic [WIDTH-1:0] res,
                       input logic v, input logic [AW-1:0] lrd, input logic [WIDTH-1:0] ld);
    regWrite_W = rw; rd_W = rd; result_W = res;
    ll_valid = v; ll_rd = lrd; ll_data = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222);
    next_cycle();
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
    checks++; if (stall_W !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_W); end
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b exp=1", ll_ready); end
    checks++; if (pending_count !== 2'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending_count); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_pipeline();
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_we got=%0b exp=1", rf_we); end
    checks++; if (rf_addr !== 5'd5) begin errors++; $display("FAIL pipe_addr got=%0d exp=5", rf_addr); end
    checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pipe_wd got=%h exp=deadbeef", rf_wd); end
    checks++; if (stall_W !== 1'b0) begin errors++; $display("FAIL pipe_stall got=%0b exp=0", stall_W); end
    next_cycle();
    drive(1'b1, 5'd0, 32'hCAFE_F00D, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_r0_we got=%0b exp=0", rf_we); end
    next_cycle();
    drive(1'b0, 5'd9, 32'h1, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_off_we got=%0b exp=0", rf_we); end
    next_cycle();
  endtask

  task automatic test_idle_port();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_1234);
    #2;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%0b exp=1", ll_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_c0_we got=%0b exp=0", rf_we); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (pending_count !== 2'd1) begin errors++; $display("FAIL idle_pending got=%0d exp=1", pending_count); end
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL idle_we got=%0b exp=1", rf_we); end
    checks++; if (rf_addr !== 5'd7) begin errors++; $display("FAIL idle_addr got=%0d exp=7", rf_addr); end
    checks++; if (rf_wd !== 32'h0000_1234) begin errors++; $display("FAIL idle_wd got=%h exp=1234", rf_wd); end
    next_cycle();
    #2;
    checks++; if (pending_count !== 2'd0) begin errors++; $display("FAIL idle_empty got=%0d exp=0", pending_count); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL idle_c2_we got=%0b exp=0", rf_we); end
    next_cycle();
  endtask

  // Brings rd 9 to its forced drain cycle; leaves the bench in that cycle.
  task automatic reach_drain(input string tag);
    drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd9, 32'h0000_0099);
    #2;
    checks++; if (rf_addr !== 5'd3 || rf_we !== 1'b1) begin errors++; $display("FAIL %s_c0 got we=%0b addr=%0d exp we=1 addr=3", tag, rf_we, rf_addr); end
    next_cycle();
    for (int c = 1; c <= SMAX; c++) begin
      drive(1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 32'h0);
      #2;
      checks++; if (stall_W !== 1'b0) begin errors++; $display("FAIL %s_wait%0d_stall got=%0b exp=0", tag, c, stall_W); end
      checks++; if (rf_addr !== 5'd3) begin errors++; $display("FAIL %s_wait%0d_addr got=%0d exp=3", tag, c, rf_addr); end
      checks++; if (pending_count !== 2'd1) begin errors++; $display("FAIL %s_wait%0d_pending got=%0d exp=1", tag, c, pending_count); end
      next_cycle();
    end
    #2;
    checks++; if (stall_W !== 1'b1) begin errors++; $display("FAIL %s_drain_stall got=%0b exp=1", tag, stall_W); end
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL %s_drain_we got=%0b exp=1", tag, rf_we); end
    checks++; if (rf_addr !== 5'd9) begin errors++; $display("FAIL %s_drain_addr got=%0d exp=9", tag, rf_addr); end
    checks++; if (rf_wd !== 32'h0000_0099) begin errors++; $display("FAIL %s_drain_wd got=%h exp=99", tag, rf_wd); end
  endtask

  task automatic test_starvation();
    reach_drain("starve");
    next_cycle();
    #2;
    checks++; if (stall_W !== 1'b0) begin errors++; $display("FAIL starve_resume_stall got=%0b exp=0", stall_W); end
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3) begin errors++; $display("FAIL starve_resume got we=%0b addr=%0d exp we=1 addr=3", rf_we, rf_addr); end
    checks++; if (pending_count !== 2'd0) begin errors++; $display("FAIL starve_resume_pending got=%0d exp=0", pending_count); end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
  endtask

  task automatic test_full();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd10, 32'hA0);
    #2;
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL full_c0_ready got=%0b exp=1", ll_ready); end
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd11, 32'hA1);
    #2;
    checks++; if (ll_ready !== 1'b1 || pending_count !== 2'd1) begin errors++; $display("FAIL full_c1 got ready=%0b pend=%0d exp ready=1 pend=1", ll_ready, pending_count); end
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hA2);
    for (int c = 2; c <= 4; c++) begin
      #2;
      checks++; if (ll_ready !== 1'b0 || pending_count !== 2'd2) begin errors++; $display("FAIL full_c%0d got ready=%0b pend=%0d exp ready=0 pend=2", c, ll_ready, pending_count); end
      next_cycle();
    end
    #2;
    checks++; if (stall_W !== 1'b1 || rf_addr !== 5'd10 || rf_wd !== 32'hA0) begin errors++; $display("FAIL full_drain got stall=%0b addr=%0d wd=%h exp stall=1 addr=10 wd=a0", stall_W, rf_addr, rf_wd); end
    checks++; if (ll_ready !== 1'b0) begin errors++; $display("FAIL full_nobypass got=%0b exp=0", ll_ready); end
    next_cycle();
    #2;
    checks++; if (ll_ready !== 1'b1 || pending_count !== 2'd1) begin errors++; $display("FAIL full_c6 got ready=%0b pend=%0d exp ready=1 pend=1", ll_ready, pending_count); end
    next_cycle();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (ll_ready !== 1'b0 || pending_count !== 2'd2) begin errors++; $display("FAIL full_c7 got ready=%0b pend=%0d exp ready=0 pend=2", ll_ready, pending_count); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd11 || rf_wd !== 32'hA1) begin errors++; $display("FAIL full_c8 got we=%0b addr=%0d wd=%h exp we=1 addr=11 wd=a1", rf_we, rf_addr, rf_wd); end
    next_cycle();
    #2;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd12 || rf_wd !== 32'hA2) begin errors++; $display("FAIL full_c9 got we=%0b addr=%0d wd=%h exp we=1 addr=12 wd=a2", rf_we, rf_addr, rf_wd); end
    next_cycle();
    #2;
    checks++; if (rf_we !== 1'b0 || pending_count !== 2'd0) begin errors++; $display("FAIL full_c10 got we=%0b pend=%0d exp we=0 pend=0", rf_we, pending_count); end
    next_cycle();
  endtask

  task automatic test_kill();
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'hAA);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3) begin errors++; $display("FAIL kill_c0 got we=%0b addr=%0d exp we=1 addr=3", rf_we, rf_addr); end
    next_cycle();
    drive(1'b1, 5'd4, 32'hBB, 1'b1, 5'd4, 32'hCC);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4 || rf_wd !== 32'hBB) begin errors++; $display("FAIL kill_pipe got we=%0b addr=%0d wd=%h exp we=1 addr=4 wd=bb", rf_we, rf_addr, rf_wd); end
    checks++; if (pending_count !== 2'd1 || ll_ready !== 1'b1) begin errors++; $display("FAIL kill_c1 got pend=%0d ready=%0b exp pend=1 ready=1", pending_count, ll_ready); end
    next_cycle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (pending_count !== 2'd1) begin errors++; $display("FAIL kill_c2_pending got=%0d exp=1", pending_count); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL kill_discard_we got=%0b exp=0", rf_we); end
    next_cycle();
    #2;
    checks++; if (pending_count !== 2'd0) begin errors++; $display("FAIL kill_noenq_pending got=%0d exp=0", pending_count); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL kill_c3_we got=%0b exp=0", rf_we); end
    next_cycle();
  endtask

  task automatic test_reset_drain();
    reach_drain("rstdrain");
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (stall_W !== 1'b0) begin errors++; $display("FAIL rstdrain_stall got=%0b exp=0", stall_W); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstdrain_we got=%0b exp=0", rf_we); end
    checks++; if (pending_count !== 2'd0) begin errors++; $display("FAIL rstdrain_pending got=%0d exp=0", pending_count); end
    checks++; if (ll_ready !== 1'b1) begin errors++; $display("FAIL rstdrain_ready got=%0b exp=1", ll_ready); end
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (stall_W !== 1'b0 || pending_count !== 2'd0 || ll_ready !== 1'b1 || rf_we !== 1'b0) begin errors++; $display("FAIL rstdrain_release got stall=%0b pend=%0d ready=%0b we=%0b exp 0/0/1/0", stall_W, pending_count, ll_ready, rf_we); end
    next_cycle();
    drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'h0);
    #2;
    checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd5) begin errors++; $display("FAIL rstdrain_pipe got we=%0b addr=%0d exp we=1 addr=5", rf_we, rf_addr); end
    next_cycle();
  endtask

  // Reference model: FIFO as a queue of {rd,data,kill}, priority applied from the rules.
  task automatic test_random();
    ent_t             mq[$];
    int               m_starve;
    int               n_before;
    logic             rw, v, hk, e_stall, e_pipe, e_ready, e_pop, e_we;
    logic [AW-1:0]    rd, lrd, e_addr;
    logic [WIDTH-1:0] res, ld, e_wd;
    ent_t             ne;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    m_starve = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rw  = ($urandom_range(9, 0) < (((cyc / 250) % 2 == 1) ? 10 : 6));
      rd  = AW'($urandom_range(7, 0));
      res = $urandom;
      v   = ($urandom_range(9, 0) < 5);
      lrd = AW'($urandom_range(7, 0));
      ld  = $urandom;
      drive(rw, rd, res, v, lrd, ld);
      hk      = (mq.size() > 0) && mq[0].kill;
      e_stall = (mq.size() > 0) && (m_starve == SMAX) && !hk;
      e_pipe  = rw && (rd != 5'd0) && !e_stall;
      e_ready = (mq.size() < DEPTH);
      e_pop = 1'b0; e_we = 1'b0; e_addr = 5'd0; e_wd = 32'h0;
      if (hk) begin
        e_pop = 1'b1;
        if (e_pipe) begin e_we = 1'b1; e_addr = rd; e_wd = res; end
      end else if (e_stall) begin
        e_pop = 1'b1; e_we = 1'b1; e_addr = mq[0].rd; e_wd = mq[0].data;
      end else if (e_pipe) begin
        e_we = 1'b1; e_addr = rd; e_wd = res;
      end else if (mq.size() > 0) begin
        e_pop = 1'b1; e_we = 1'b1; e_addr = mq[0].rd; e_wd = mq[0].data;
      end
      #2;
      checks++; if (stall_W !== e_stall) begin errors++; $display("FAIL rnd%0d_stall got=%0b exp=%0b", cyc, stall_W, e_stall); end
      checks++; if (rf_we !== e_we) begin errors++; $display("FAIL rnd%0d_we got=%0b exp=%0b", cyc, rf_we, e_we); end
      checks++; if (ll_ready !== e_ready) begin errors++; $display("FAIL rnd%0d_ready got=%0b exp=%0b", cyc, ll_ready, e_ready); end
      checks++; if (pending_count !== PCW'(mq.size())) begin errors++; $display("FAIL rnd%0d_pending got=%0d exp=%0d", cyc, pending_count, mq.size()); end
      if (e_we) begin
        checks++; if (rf_addr !== e_addr || rf_wd !== e_wd) begin errors++; $display("FAIL rnd%0d_port got addr=%0d wd=%h exp addr=%0d wd=%h", cyc, rf_addr, rf_wd, e_addr, e_wd); end
      end
      checks++; if (rf_we === 1'b1 && rf_addr === 5'd0) begin errors++; $display("FAIL rnd%0d_r0 got addr=0 with we=1 exp no write to r0", cyc); end
      n_before = mq.size();
      if (e_pop) mq.delete(0);
      if (e_pipe) begin
        foreach (mq[k]) if (mq[k].rd == rd) mq[k].kill = 1'b1;
      end
      if (v && e_ready && (lrd != 5'd0) && !(e_pipe && lrd == rd)) begin
        ne.rd = lrd; ne.data = ld; ne.kill = 1'b0;
        mq.push_back(ne);
      end
      m_starve = (n_before == 0 || e_pop) ? 0 : ((m_starve < SMAX) ? m_starve + 1 : SMAX);
      next_cycle();
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_pipeline();
    test_idle_port();
    test_starvation();
    test_full();
    test_kill();
    test_reset_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
